// File: rtl/i8228_sysctl.sv
// 8228-style system controller: latches the 8080 status byte on the
// generator's strobe, produces registered active-low bus commands,
// splits the CPU data bus into CPU-side and system-side paths, and
// optionally supplies RST 7 or a 3-byte CALL during interrupt acknowledge.
module i8228_sysctl #(
  parameter int          INT_MODE   = 1,
  parameter logic [15:0] INT_VECTOR = 16'h0038
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ststb_n,
  input  logic       dbin,
  input  logic       wr_n,
  input  logic       busen_n,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  input  logic [7:0] sys_din,
  output logic [7:0] sys_dout,
  output logic [7:0] status,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n,
  output logic       inta_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2
  } inj_t;

  inj_t inj_state;
  logic dbin_q;

  // Byte placed on the CPU bus while an acknowledge is being answered.
  function automatic logic [7:0] inject_byte(input inj_t s);
    logic [7:0] b;
    if (INT_MODE == 1) begin
      b = 8'hFF;
    end else begin
      case (s)
        IDLE:    b = 8'hCD;
        B1:      b = INT_VECTOR[7:0];
        B2:      b = INT_VECTOR[15:8];
        default: b = 8'hCD;
      endcase
    end
    return b;
  endfunction

  // Status latch, write-data holding register and registered commands.
  // The strobe phase and a released bus both force every command inactive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status   <= 8'h00;
      sys_dout <= 8'h00;
      memr_n   <= 1'b1;
      memw_n   <= 1'b1;
      ior_n    <= 1'b1;
      iow_n    <= 1'b1;
      inta_n   <= 1'b1;
    end else begin
      if (!ststb_n) status <= cpu_dout;
      if (!wr_n && !busen_n) sys_dout <= cpu_dout;
      if (!ststb_n || busen_n) begin
        memr_n <= 1'b1;
        memw_n <= 1'b1;
        ior_n  <= 1'b1;
        iow_n  <= 1'b1;
        inta_n <= 1'b1;
      end else begin
        memr_n <= ~(status[7] & dbin);
        ior_n  <= ~(status[6] & dbin);
        inta_n <= ~(status[0] & dbin);
        memw_n <= ~(~wr_n & ~status[4]);
        iow_n  <= ~(~wr_n & status[4]);
      end
    end
  end

  // CALL injection sequencer: steps on each falling dbin of an acknowledge,
  // and any strobe that is not a continuation of the CALL restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_state <= IDLE;
      dbin_q    <= 1'b0;
    end else begin
      dbin_q <= dbin;
      if (INT_MODE != 2) begin
        inj_state <= IDLE;
      end else if (!ststb_n) begin
        if (!cpu_dout[0] || cpu_dout[5]) inj_state <= IDLE;
      end else if (dbin_q && !dbin && status[0]) begin
        case (inj_state)
          IDLE:    inj_state <= B1;
          B1:      inj_state <= B2;
          B2:      inj_state <= IDLE;
          default: inj_state <= IDLE;
        endcase
      end
    end
  end

  // CPU-side read data: injected opcode/operand during acknowledge, else system bus.
  always_comb begin
    cpu_din = sys_din;
    if (INT_MODE != 0 && dbin && status[0]) cpu_din = inject_byte(inj_state);
  end

endmodule

// File: tb/tb_i8228_sysctl.sv
// Bench for i8228_sysctl: a CALL-injecting instance (INT_VECTOR 0x1234) and
// an RST 7 instance share stimulus; expectations travel through a queue.
module tb_i8228_sysctl;

  typedef struct {
    logic       ststb_n;
    logic       dbin;
    logic       wr_n;
    logic       busen_n;
    logic [7:0] cpu_dout;
    logic [7:0] sys_din;
    logic [7:0] status;
    logic [4:0] cmd;      // {memr_n, memw_n, ior_n, iow_n, inta_n}
    logic [7:0] sys_dout;
    logic [7:0] din2;     // cpu_din of the CALL instance
    logic [7:0] din1;     // cpu_din of the RST 7 instance
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ststb_n, dbin, wr_n, busen_n;
  logic [7:0] cpu_dout, sys_din;
  logic [7:0] cpu_din2, sys_dout2, status2;
  logic       memr2, memw2, ior2, iow2, inta2;
  logic [7:0] cpu_din1, sys_dout1, status1;
  logic       memr1, memw1, ior1, iow1, inta1;

  int   applied = 0;
  int   miscompares = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  i8228_sysctl #(.INT_MODE(2), .INT_VECTOR(16'h1234)) dut (
    .clk(clk), .reset_n(reset_n), .ststb_n(ststb_n), .dbin(dbin), .wr_n(wr_n),
    .busen_n(busen_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din2), .sys_din(sys_din),
    .sys_dout(sys_dout2), .status(status2), .memr_n(memr2), .memw_n(memw2),
    .ior_n(ior2), .iow_n(iow2), .inta_n(inta2));

  i8228_sysctl #(.INT_MODE(1), .INT_VECTOR(16'h1234)) dut1 (
    .clk(clk), .reset_n(reset_n), .ststb_n(ststb_n), .dbin(dbin), .wr_n(wr_n),
    .busen_n(busen_n), .cpu_dout(cpu_dout), .cpu_din(cpu_din1), .sys_din(sys_din),
    .sys_dout(sys_dout1), .status(status1), .memr_n(memr1), .memw_n(memw1),
    .ior_n(ior1), .iow_n(iow1), .inta_n(inta1));

  function automatic vec_t mk(input logic ss, input logic db, input logic wr,
                              input logic be, input logic [7:0] cd, input logic [7:0] sd,
                              input logic [7:0] st, input logic [4:0] cmd,
                              input logic [7:0] sdo, input logic [7:0] d2,
                              input logic [7:0] d1);
    vec_t v;
    v.ststb_n = ss; v.dbin = db; v.wr_n = wr; v.busen_n = be;
    v.cpu_dout = cd; v.sys_din = sd; v.status = st; v.cmd = cmd;
    v.sys_dout = sdo; v.din2 = d2; v.din1 = d1;
    return v;
  endfunction

  task automatic add(input logic ss, input logic db, input logic wr, input logic be,
                     input logic [7:0] cd, input logic [7:0] sd, input logic [7:0] st,
                     input logic [4:0] cmd, input logic [7:0] sdo,
                     input logic [7:0] d2, input logic [7:0] d1);
    tbl.push_back(mk(ss, db, wr, be, cd, sd, st, cmd, sdo, d2, d1));
  endtask

  task automatic drive(input vec_t v);
    ststb_n = v.ststb_n; dbin = v.dbin; wr_n = v.wr_n; busen_n = v.busen_n;
    cpu_dout = v.cpu_dout; sys_din = v.sys_din;
  endtask

  // Pop the oldest expectation and compare it with both instances now.
  task automatic check_now(input string name);
    vec_t e;
    logic [4:0] c2, c1;
    e  = exp_q.pop_front();
    c2 = {memr2, memw2, ior2, iow2, inta2};
    c1 = {memr1, memw1, ior1, iow1, inta1};
    applied++;
    if (status2 !== e.status || c2 !== e.cmd || sys_dout2 !== e.sys_dout ||
        cpu_din2 !== e.din2 || status1 !== e.status || c1 !== e.cmd ||
        sys_dout1 !== e.sys_dout || cpu_din1 !== e.din1) begin
      miscompares++;
      $display("FAIL %s: got st=%h cmd=%b sdo=%h din=%h | st1=%h cmd1=%b sdo1=%h din1=%h ; want st=%h cmd=%b sdo=%h din=%h din1=%h",
               name, status2, c2, sys_dout2, cpu_din2, status1, c1, sys_dout1, cpu_din1,
               e.status, e.cmd, e.sys_dout, e.din2, e.din1);
    end
  endtask

  // Drive one vector, let one clock edge pass, then compare.
  task automatic apply(input vec_t v, input string name);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check_now(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    // Reset while the CPU drives read and write strobes.
    reset_n = 1'b0;
    drive(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h3E, 8'h00, 5'h1F, 8'h00, 8'h3E, 8'h3E));
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h3E, 8'h00, 5'h1F, 8'h00, 8'h3E, 8'h3E));
    check_now("reset");
    wr_n = 1'b1;
    ststb_n = 1'b1;
    reset_n = 1'b1;

    // idle after release
    add(1,1,1,0,8'h00,8'h3E, 8'h00,5'b11111,8'h00,8'h3E,8'h3E);
    add(1,0,1,0,8'h00,8'h3E, 8'h00,5'b11111,8'h00,8'h3E,8'h3E);
    // memory read, M1
    add(0,0,1,0,8'hA2,8'h3E, 8'hA2,5'b11111,8'h00,8'h3E,8'h3E);
    add(1,1,1,0,8'hA2,8'h3E, 8'hA2,5'b01111,8'h00,8'h3E,8'h3E);
    add(1,0,1,0,8'hA2,8'h3E, 8'hA2,5'b11111,8'h00,8'h3E,8'h3E);
    // I/O write then memory write
    add(0,0,1,0,8'h10,8'h3E, 8'h10,5'b11111,8'h00,8'h3E,8'h3E);
    add(1,0,0,0,8'h55,8'h3E, 8'h10,5'b11101,8'h55,8'h3E,8'h3E);
    add(1,0,1,0,8'h66,8'h3E, 8'h10,5'b11111,8'h55,8'h3E,8'h3E);
    add(0,0,1,0,8'h00,8'h3E, 8'h00,5'b11111,8'h55,8'h3E,8'h3E);
    add(1,0,0,0,8'h77,8'h3E, 8'h00,5'b10111,8'h77,8'h3E,8'h3E);
    add(1,0,1,0,8'h77,8'h3E, 8'h00,5'b11111,8'h77,8'h3E,8'h3E);
    // bus released during a memory read
    add(0,0,1,1,8'h82,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,1,8'h82,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,0,1,8'h99,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h99,8'h3E, 8'h82,5'b01111,8'h77,8'h3E,8'h3E);
    add(1,0,1,0,8'h99,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    // strobe overlapping dbin, then I/O read
    add(0,1,1,0,8'h40,8'h3E, 8'h40,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h40,8'h3E, 8'h40,5'b11011,8'h77,8'h3E,8'h3E);
    add(1,0,1,0,8'h40,8'h3E, 8'h40,5'b11111,8'h77,8'h3E,8'h3E);
    // full CALL 0x1234 acknowledge
    add(0,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h23,8'h3E, 8'h23,5'b11110,8'h77,8'hCD,8'hFF);
    add(1,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);
    add(0,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h01,8'h5A, 8'h01,5'b11110,8'h77,8'h34,8'hFF);
    add(1,0,1,0,8'h01,8'h5A, 8'h01,5'b11111,8'h77,8'h5A,8'h5A);
    add(0,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h01,8'h3E, 8'h01,5'b11110,8'h77,8'h12,8'hFF);
    add(1,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E);
    // sequencer wrapped back to the opcode byte
    add(0,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h01,8'h3E, 8'h01,5'b11110,8'h77,8'hCD,8'hFF);
    add(1,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E);
    // new M1 acknowledge restarts from mid-sequence
    add(0,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h23,8'h3E, 8'h23,5'b11110,8'h77,8'hCD,8'hFF);
    add(1,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);
    // aborted CALL: normal fetch, then a fresh acknowledge
    add(0,0,1,0,8'h82,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h82,8'h5A, 8'h82,5'b01111,8'h77,8'h5A,8'h5A);
    add(1,0,1,0,8'h82,8'h3E, 8'h82,5'b11111,8'h77,8'h3E,8'h3E);
    add(0,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);
    add(1,1,1,0,8'h23,8'h3E, 8'h23,5'b11110,8'h77,8'hCD,8'hFF);
    add(1,0,1,0,8'h23,8'h3E, 8'h23,5'b11111,8'h77,8'h3E,8'h3E);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of the operand fetch of a CALL.
    apply(mk(0,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h77,8'h3E,8'h3E), "pre_rst_strobe");
    apply(mk(1,1,1,0,8'h01,8'h3E, 8'h01,5'b11110,8'h77,8'h34,8'hFF), "pre_rst_operand");
    #3;
    reset_n = 1'b0;
    #1;
    exp_q.push_back(mk(1,1,1,0,8'h01,8'h3E, 8'h00,5'b11111,8'h00,8'h3E,8'h3E));
    check_now("async_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(mk(0,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h00,8'h3E,8'h3E), "post_rst_strobe");
    apply(mk(1,1,1,0,8'h01,8'h3E, 8'h01,5'b11110,8'h00,8'hCD,8'hFF), "post_rst_restart");
    apply(mk(1,0,1,0,8'h01,8'h3E, 8'h01,5'b11111,8'h00,8'h3E,8'h3E), "post_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
